// File: rtl/m_stage_lsu_pkg.sv
// Shared types for the memory stage: FSM states, memory funct3 codes and access-size decode.
package core_types_pkg;

  typedef enum logic [1:0] {IDLE, REQ, RSP} m_state_e;
  typedef enum logic [1:0] {SZ_B, SZ_H, SZ_W} m_size_e;

  localparam logic [2:0] LB  = 3'b000;
  localparam logic [2:0] LH  = 3'b001;
  localparam logic [2:0] LW  = 3'b010;
  localparam logic [2:0] LBU = 3'b100;
  localparam logic [2:0] LHU = 3'b101;
  localparam logic [2:0] SB  = 3'b000;
  localparam logic [2:0] SH  = 3'b001;
  localparam logic [2:0] SW  = 3'b010;

  // Any funct3 that is not a byte/half encoding falls back to a full-word access.
  function automatic m_size_e access_size(input logic [2:0] funct3, input logic is_store);
    m_size_e sz;
    sz = SZ_W;
    if (is_store) begin
      case (funct3)
        SB:      sz = SZ_B;
        SH:      sz = SZ_H;
        default: sz = SZ_W;
      endcase
    end else begin
      case (funct3)
        LB, LBU: sz = SZ_B;
        LH, LHU: sz = SZ_H;
        default: sz = SZ_W;
      endcase
    end
    return sz;
  endfunction

endpackage

// File: rtl/m_stage_lsu_if.sv
// Data-memory request/response bus between the memory stage (master) and the data memory (slave).
interface m_stage_lsu_if #(parameter int N_BITS = 32);
  logic                  mem_req_valid;
  logic                  mem_req_ready;
  logic [N_BITS-1:0]     mem_req_addr;
  logic                  mem_req_we;
  logic [N_BITS/8-1:0]   mem_req_wstrb;
  logic [N_BITS-1:0]     mem_req_wdata;
  logic                  mem_rsp_valid;
  logic [N_BITS-1:0]     mem_rsp_data;

  modport master (
    output mem_req_valid, mem_req_addr, mem_req_we, mem_req_wstrb, mem_req_wdata,
    input  mem_req_ready, mem_rsp_valid, mem_rsp_data
  );

  modport slave (
    input  mem_req_valid, mem_req_addr, mem_req_we, mem_req_wstrb, mem_req_wdata,
    output mem_req_ready, mem_rsp_valid, mem_rsp_data
  );
endinterface

// File: rtl/m_stage_lsu_load_align.sv
// Combinational load extractor: picks the byte/half at the given offset and sign/zero-extends it.
module m_load_align
  import core_types_pkg::*;
#(
  parameter int N_BITS = 32,
  parameter int OFF_W  = 2
) (
  input  logic [N_BITS-1:0] data,
  input  logic [OFF_W-1:0]  offset,
  input  logic [2:0]        funct3,
  output logic [N_BITS-1:0] result
);

  logic [N_BITS-1:0]  shifted;
  logic signed [7:0]  byte_s;
  logic signed [15:0] half_s;

  assign shifted = data >> {offset, 3'b000};
  assign byte_s  = signed'(shifted[7:0]);
  assign half_s  = signed'(shifted[15:0]);

  always_comb begin
    result = data;
    case (funct3)
      LB:      result = {{(N_BITS-8){byte_s[7]}}, byte_s};
      LH:      result = {{(N_BITS-16){half_s[15]}}, half_s};
      LBU:     result = {{(N_BITS-8){1'b0}}, shifted[7:0]};
      LHU:     result = {{(N_BITS-16){1'b0}}, shifted[15:0]};
      default: result = data;
    endcase
  end

endmodule

// File: rtl/m_stage_lsu.sv
// RV32 memory stage with load/store unit. Define M_STAGE_MISALIGN_CHECK_EN to trap misaligned
// half/word accesses with err instead of silently aligning them down.
module m_stage_lsu
  import core_types_pkg::*;
#(
  parameter int N_BITS      = 32,
  parameter int RSP_TIMEOUT = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              x_valid,
  output logic              x_ready,
  input  logic              x_is_load,
  input  logic              x_is_store,
  input  logic [2:0]        x_funct3,
  input  logic [N_BITS-1:0] X_stage_data,
  input  logic [N_BITS-1:0] x_store_data,
  m_stage_lsu_if.master     mem,
  output logic              w_valid,
  output logic [N_BITS-1:0] out,
  output logic              err
);

  localparam int NB    = N_BITS / 8;
  localparam int OFF_W = $clog2(NB);
`ifdef M_STAGE_MISALIGN_CHECK_EN
  localparam bit CHECK_MISALIGN = 1'b1;
`else
  localparam bit CHECK_MISALIGN = 1'b0;
`endif

  m_state_e          state;
  logic [N_BITS-1:0] addr_q;
  logic [OFF_W-1:0]  off_q;
  logic [2:0]        funct3_q;
  logic              we_q;
  logic [NB-1:0]     wstrb_q;
  logic [N_BITS-1:0] wdata_q;
  logic [31:0]       tmo_cnt;

  m_size_e           size_x;
  logic [OFF_W-1:0]  off_raw;
  logic [OFF_W-1:0]  off_eff;
  logic              misalign;
  logic [NB-1:0]     wstrb_x;
  logic [N_BITS-1:0] wdata_x;
  logic [N_BITS-1:0] load_result;

  // Request fields are computed once at accept time and held in registers while in REQ.
  always_comb begin
    size_x   = access_size(x_funct3, x_is_store);
    off_raw  = X_stage_data[OFF_W-1:0];
    off_eff  = '0;
    misalign = 1'b0;
    wstrb_x  = '1;
    wdata_x  = x_store_data;
    case (size_x)
      SZ_B: begin
        off_eff = off_raw;
        wstrb_x = NB'(1) << off_eff;
        wdata_x = {NB{x_store_data[7:0]}};
      end
      SZ_H: begin
        off_eff  = {off_raw[OFF_W-1:1], 1'b0};
        misalign = off_raw[0];
        wstrb_x  = NB'(3) << off_eff;
        wdata_x  = {(NB/2){x_store_data[15:0]}};
      end
      default: begin
        off_eff  = '0;
        misalign = |off_raw;
      end
    endcase
    if (!x_is_store) begin
      wstrb_x = '0;
      wdata_x = '0;
    end
  end

  m_load_align #(.N_BITS(N_BITS), .OFF_W(OFF_W)) u_load_align (
    .data   (mem.mem_rsp_data),
    .offset (off_q),
    .funct3 (funct3_q),
    .result (load_result)
  );

  assign x_ready           = (state == IDLE);
  assign mem.mem_req_valid = (state == REQ);
  assign mem.mem_req_addr  = addr_q;
  assign mem.mem_req_we    = we_q;
  assign mem.mem_req_wstrb = wstrb_q;
  assign mem.mem_req_wdata = wdata_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      addr_q   <= '0;
      off_q    <= '0;
      funct3_q <= '0;
      we_q     <= 1'b0;
      wstrb_q  <= '0;
      wdata_q  <= '0;
      tmo_cnt  <= '0;
      w_valid  <= 1'b0;
      out      <= '0;
      err      <= 1'b0;
    end else begin
      w_valid <= 1'b0;
      err     <= 1'b0;
      case (state)
        IDLE: begin
          if (x_valid) begin
            if (x_is_load || x_is_store) begin
              if (CHECK_MISALIGN && misalign) begin
                w_valid <= 1'b1;
                err     <= 1'b1;
                out     <= '0;
              end else begin
                addr_q   <= {X_stage_data[N_BITS-1:OFF_W], {OFF_W{1'b0}}};
                off_q    <= off_eff;
                funct3_q <= x_funct3;
                we_q     <= x_is_store;
                wstrb_q  <= wstrb_x;
                wdata_q  <= wdata_x;
                state    <= REQ;
              end
            end else begin
              out     <= X_stage_data;
              w_valid <= 1'b1;
            end
          end
        end
        REQ: begin
          if (mem.mem_req_ready) begin
            tmo_cnt <= '0;
            if (we_q) begin
              w_valid <= 1'b1;
              out     <= '0;
              state   <= IDLE;
            end else begin
              state <= RSP;
            end
          end
        end
        RSP: begin
          if (mem.mem_rsp_valid) begin
            out     <= load_result;
            w_valid <= 1'b1;
            state   <= IDLE;
          end else if (RSP_TIMEOUT > 0 && tmo_cnt == 32'(RSP_TIMEOUT - 1)) begin
            out     <= '0;
            w_valid <= 1'b1;
            err     <= 1'b1;
            state   <= IDLE;
          end else begin
            tmo_cnt <= tmo_cnt + 32'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
